// File: rtl/phase_comp_cal_sequencer_if.sv
// -----------------------------------------------------------------------------
// phase_comp_cal_sequencer_if
// Pin bundle between the calibration sequencer and the 16-lane, 2-bit
// phase-compensation control block.
//   enable          : tracking enable to the controlled block
//   en_mid          : lane-7 update enable
//   freeze[15:0]    : per-lane freeze
//   reg_write_readb : 1 = load access, 0 = read access
//   reg_num[3:0]    : lane select for the register access
//   reg_load_data   : value written on a load access
//   reg_read_data   : readback of lane reg_num (combinational in the block)
// Modports: master = sequencer side, slave = controlled-block side.
// -----------------------------------------------------------------------------
interface phase_comp_cal_sequencer_if;
    logic        enable;
    logic        en_mid;
    logic [15:0] freeze;
    logic        reg_write_readb;
    logic [3:0]  reg_num;
    logic [1:0]  reg_load_data;
    logic [1:0]  reg_read_data;

    modport master (
        output enable, en_mid, freeze, reg_write_readb, reg_num, reg_load_data,
        input  reg_read_data
    );

    modport slave (
        input  enable, en_mid, freeze, reg_write_readb, reg_num, reg_load_data,
        output reg_read_data
    );
endinterface

// File: rtl/phase_comp_cal_sequencer.sv
// -----------------------------------------------------------------------------
// phase_comp_cal_sequencer
// Calibration sequencer for the 16-lane, 2-bit phase-compensation block.
// On start it loads init_code into every lane, then enables round-robin
// tracking and reads each lane once per round. A lane freezes once its code
// has stayed unchanged for stable_rounds rounds; the run ends when all lanes
// are frozen or the round budget (max_rounds, 0 = 256) runs out.
//
// Ports:
//   clk, resetb      : clock, asynchronous active-low reset
//   start_i          : one-cycle start pulse (accepted in IDLE or DONE)
//   abort_i          : level, forces IDLE; overrides everything else
//   init_code_i      : code loaded into every lane
//   max_rounds_i     : tracking round budget, 0 = 256
//   stable_rounds_i  : unchanged rounds needed to freeze, 0 = never freeze
//   busy_o / done_o  : in INIT or TRACK / in DONE
//   timeout_o        : in DONE, 1 = budget expired before all lanes froze
//   pc               : control/register-access pins of the controlled block
//
// Build option: define PHASE_COMP_SEQ_DITHER_EN to treat an A-B-A dither
// (read equal to the code before the last one) as an unchanged code.
// -----------------------------------------------------------------------------
module phase_comp_cal_sequencer #(
    parameter int MID_START = 4
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [1:0] init_code_i,
    input  logic [7:0] max_rounds_i,
    input  logic [3:0] stable_rounds_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       timeout_o,
    phase_comp_cal_sequencer_if.master pc
);
    typedef enum logic [1:0] {S_IDLE, S_INIT, S_TRACK, S_DONE} state_t;

    localparam logic [8:0] MID_START_W = 9'(MID_START);

    state_t      state_q, state_d;
    logic [3:0]  lane_q, lane_d;
    logic [8:0]  round_q, round_d;   // 9 bits so a 256-round budget fits
    logic        timeout_q, timeout_d;
    logic [15:0] freeze_q, freeze_d;

    logic [15:0][1:0] last_all;
    logic [15:0][3:0] stab_all;
    logic [1:0]  rd_val;
    logic [1:0]  last_cur;
    logic [3:0]  stab_cur;
    logic        same;
    logic [3:0]  stab_new;
    logic        frz_new;
    logic        init_wr;
    logic        track_upd;
    logic [15:0] freeze_hit;
    logic        all_frozen;
    logic [8:0]  budget;
    logic        budget_hit;

    assign rd_val   = pc.reg_read_data;
    assign last_cur = last_all[lane_q];
    assign stab_cur = stab_all[lane_q];

`ifdef PHASE_COMP_SEQ_DITHER_EN
    logic [15:0][1:0] prev2_all;
    logic [1:0]  prev2_cur;
    logic [1:0]  prev2_new;
    logic        exact;
    assign prev2_cur = prev2_all[lane_q];
    assign exact     = (rd_val == last_cur);
    assign same      = exact || (rd_val == prev2_cur);
    // On a dither hit last/prev2 swap; on a change the history shifts.
    // Either way the new "last" is the value just read.
    assign prev2_new = exact ? prev2_cur : last_cur;
`else
    assign same      = (rd_val == last_cur);
`endif

    assign stab_new   = !same ? 4'd0 : ((stab_cur == 4'd15) ? 4'd15 : stab_cur + 4'd1);
    assign frz_new    = (stable_rounds_i != 4'd0) && (stab_new >= stable_rounds_i);
    // Abort suppresses this cycle's lane update so freeze is held as it was.
    assign init_wr    = (state_q == S_INIT)  && !abort_i;
    assign track_upd  = (state_q == S_TRACK) && !abort_i;
    assign freeze_hit = (track_upd && frz_new) ? (16'd1 << lane_q) : 16'd0;
    assign all_frozen = &(freeze_q | freeze_hit);
    assign budget     = (max_rounds_i == 8'd0) ? 9'd256 : {1'b0, max_rounds_i};
    assign budget_hit = (lane_q == 4'd15) && ((round_q + 9'd1) == budget);

    // Per-lane history registers.
    for (genvar gi = 0; gi < 16; gi++) begin : g_lane
        logic       sel;
        logic [1:0] last_q;
        logic [3:0] stab_q;
        assign sel = (lane_q == 4'(gi));
        always_ff @(posedge clk or negedge resetb) begin
            if (!resetb) begin
                last_q <= 2'd0;
                stab_q <= 4'd0;
            end else if (sel && init_wr) begin
                last_q <= init_code_i;
                stab_q <= 4'd0;
            end else if (sel && track_upd) begin
                last_q <= rd_val;
                stab_q <= stab_new;
            end
        end
        assign last_all[gi] = last_q;
        assign stab_all[gi] = stab_q;
`ifdef PHASE_COMP_SEQ_DITHER_EN
        logic [1:0] prev2_q;
        always_ff @(posedge clk or negedge resetb) begin
            if (!resetb) begin
                prev2_q <= 2'd0;
            end else if (sel && init_wr) begin
                prev2_q <= init_code_i;
            end else if (sel && track_upd) begin
                prev2_q <= prev2_new;
            end
        end
        assign prev2_all[gi] = prev2_q;
`endif
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= S_IDLE;
            lane_q    <= 4'd0;
            round_q   <= 9'd0;
            timeout_q <= 1'b0;
            freeze_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            round_q   <= round_d;
            timeout_q <= timeout_d;
            freeze_q  <= freeze_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        round_d   = round_q;
        timeout_d = timeout_q;
        freeze_d  = freeze_q | freeze_hit;
        if (abort_i) begin
            state_d   = S_IDLE;
            lane_d    = 4'd0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_d   = S_INIT;
                        lane_d    = 4'd0;
                        round_d   = 9'd0;
                        timeout_d = 1'b0;
                        freeze_d  = 16'd0;
                    end
                end
                S_INIT: begin
                    lane_d = lane_q + 4'd1;   // wraps to 0 after lane 15
                    if (lane_q == 4'd15) state_d = S_TRACK;
                end
                S_TRACK: begin
                    lane_d = lane_q + 4'd1;
                    if (lane_q == 4'd15) round_d = round_q + 9'd1;
                    if (all_frozen) begin
                        state_d   = S_DONE;
                        lane_d    = 4'd0;
                        timeout_d = 1'b0;
                    end else if (budget_hit) begin
                        state_d   = S_DONE;
                        lane_d    = 4'd0;
                        timeout_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign pc.enable          = (state_q == S_TRACK);
    assign pc.en_mid          = (state_q == S_TRACK) && (round_q >= MID_START_W);
    assign pc.freeze          = freeze_q;
    assign pc.reg_write_readb = (state_q == S_INIT);
    assign pc.reg_num         = lane_q;
    assign pc.reg_load_data   = (state_q == S_INIT) ? init_code_i : 2'd0;
    assign busy_o             = (state_q == S_INIT) || (state_q == S_TRACK);
    assign done_o             = (state_q == S_DONE);
    assign timeout_o          = timeout_q;
endmodule
